bus_copy_master: RTL and testbench

BUS_COPY_MASTER -- requirements
Module: bus_copy_master

---
 rtl/bus_master_pkg.sv | 22 ++
 rtl/bus_copy_master_if.sv | 37 +++
 rtl/bus_copy_master.sv | 152 +++++++++++++++
 tb/tb_bus_copy_master.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus copy master.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - BE_FULL     : byte-enable pattern for full-word transfers
//   - WORD_STRIDE : byte increment between consecutive 32-bit words
//   - word_align  : clears address bits [1:0]
package bus_master_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_FIN     = 3'd4;

    localparam logic [3:0]  BE_FULL     = 4'hf;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

    // Byte addresses are treated as word addresses; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/bus_copy_master_if.sv
// Initiator-side bus between the copy master and a memory/responder.
//   bus_req_o    : request valid (master -> slave)
//   bus_we_o     : 1 = write, 0 = read
//   bus_addr_bo  : word-aligned byte address
//   bus_be_bo    : byte enables
//   bus_wdata_bo : write data
//   bus_ack_i    : request accepted (slave -> master)
//   bus_resp_i   : read data valid
//   bus_rdata_bi : read data
//
// Handshake: a request transfers in the cycle where bus_req_o and bus_ack_i are
// both high. While bus_req_o=1 and bus_ack_i=0 the master holds bus_we_o,
// bus_addr_bo and bus_wdata_bo constant and never drops bus_req_o. A read
// returns exactly one bus_resp_i pulse, some cycles after its acknowledge,
// carrying bus_rdata_bi; only one read is outstanding at any time.
interface bus_copy_master_if;

    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_bo;
    logic [3:0]  bus_be_bo;
    logic [31:0] bus_wdata_bo;
    logic        bus_ack_i;
    logic        bus_resp_i;
    logic [31:0] bus_rdata_bi;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo,
        input  bus_ack_i, bus_resp_i, bus_rdata_bi
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_bo, bus_be_bo, bus_wdata_bo,
        output bus_ack_i, bus_resp_i, bus_rdata_bi
    );

endinterface

// File: rtl/bus_copy_master.sv
// Word-by-word memory copy engine: reads a word from src, writes it to dst,
// advances both pointers, repeats len times.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   start_i               : start request (sampled in IDLE only)
//   src_bi, dst_bi        : source / destination byte address (bits [1:0] ignored)
//   len_bi                : number of 32-bit words to copy
//   abort_i               : stop after the word in progress
//   busy_o                : high whenever not IDLE
//   done_o                : one-cycle completion pulse
//   err_o                 : sticky read-response timeout flag
//   cnt_bo                : words fully written since last accepted start
//   state_o               : current FSM state (debug)
//   bus                   : initiator bus (bus_copy_master_if.master)
// Parameters:
//   LEN_W        : width of len_bi / cnt_bo
//   RESP_TIMEOUT : RD_WAIT watchdog in cycles, 0 disables it
module bus_copy_master
    import bus_master_pkg::*;
#(
    parameter int LEN_W        = 16,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [31:0]        src_bi,
    input  logic [31:0]        dst_bi,
    input  logic [LEN_W-1:0]   len_bi,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [LEN_W-1:0]   cnt_bo,
    output logic [2:0]         state_o,
    bus_copy_master_if.master  bus
);

    localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        TMO_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_ONE = 1;
    localparam logic [LEN_W-1:0] CNT_ONE = 1;

    logic [2:0]       state_q, state_d;
    logic [31:0]      src_q, dst_q, buf_q;
    logic [LEN_W-1:0] len_q, cnt_q, cnt_next;
    logic             err_q, abort_q;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit, last_word, stop_now;

    assign cnt_next  = cnt_q + CNT_ONE;
    assign last_word = (cnt_next == len_q);
    // An abort raised in the same cycle as the write acknowledge still counts.
    assign stop_now  = last_word || abort_q || abort_i;
    // tmo_q counts RD_WAIT cycles from 0, so hitting TMO_LAST without a
    // response means RD_WAIT has lasted RESP_TIMEOUT cycles.
    assign tmo_hit   = (RESP_TIMEOUT != 0) && (state_q == ST_RD_WAIT) &&
                       !bus.bus_resp_i && (tmo_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = (len_bi == '0) ? ST_FIN : ST_RD_REQ;
            end
            ST_RD_REQ: begin
                if (bus.bus_ack_i) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.bus_resp_i)  state_d = ST_WR_REQ;
                else if (tmo_hit)    state_d = ST_FIN;
            end
            ST_WR_REQ: begin
                if (bus.bus_ack_i) state_d = stop_now ? ST_FIN : ST_RD_REQ;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        src_q <= word_align(src_bi);
                        dst_q <= word_align(dst_bi);
                        len_q <= len_bi;
                        cnt_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                ST_RD_REQ: begin
                    tmo_q <= '0;
                end
                ST_RD_WAIT: begin
                    if (bus.bus_resp_i) begin
                        buf_q <= bus.bus_rdata_bi;
                    end else begin
                        tmo_q <= tmo_q + TMO_ONE;
                        if (tmo_hit) err_q <= 1'b1;
                    end
                end
                ST_WR_REQ: begin
                    if (bus.bus_ack_i) begin
                        cnt_q <= cnt_next;
                        src_q <= src_q + WORD_STRIDE;
                        dst_q <= dst_q + WORD_STRIDE;
                    end
                end
                default: ;
            endcase
            // FIN always leads to IDLE, so clearing here clears on IDLE entry.
            if (state_q == ST_FIN)
                abort_q <= 1'b0;
            else if (state_q != ST_IDLE && abort_i)
                abort_q <= 1'b1;
        end
    end

    // Bus outputs depend on registered state only; fields change only on
    // acknowledge, so they stay stable while a request is waiting.
    assign bus.bus_req_o    = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
    assign bus.bus_we_o     = (state_q == ST_WR_REQ);
    assign bus.bus_addr_bo  = (state_q == ST_RD_REQ) ? src_q :
                              (state_q == ST_WR_REQ) ? dst_q : 32'h0;
    assign bus.bus_wdata_bo = (state_q == ST_WR_REQ) ? buf_q : 32'h0;
    assign bus.bus_be_bo    = BE_FULL;

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_FIN);
    assign err_o   = err_q;
    assign cnt_bo  = cnt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_bus_copy_master.sv
module tb_bus_copy_master;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          ack_d;
    int          resp_d;
    int          abort_word;
    bit          withhold;
    int          exp_done;
    int          exp_cnt;
    int          exp_reads;
    bit          exp_err;
  } vec_t;

  localparam int NVEC = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_bi = '0;
  logic [31:0] dst_bi = '0;
  logic [15:0] len_bi = '0;
  logic        abort_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [15:0] cnt_bo;
  logic [2:0]  state_o;

  bus_copy_master_if bif();

  bus_copy_master #(.LEN_W(16), .RESP_TIMEOUT(5)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .src_bi  (src_bi),
    .dst_bi  (dst_bi),
    .len_bi  (len_bi),
    .abort_i (abort_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .cnt_bo  (cnt_bo),
    .state_o (state_o),
    .bus     (bif.master)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- responder model ----------------
  int          ack_d = 0;
  int          resp_d = 1;
  bit          withhold = 1'b0;
  int          ack_wait = 0;
  bit          rd_pend = 1'b0;
  int          rd_wait = 0;
  logic [31:0] raddr_q = '0;

  assign bif.bus_ack_i    = bif.bus_req_o && (ack_wait >= ack_d);
  assign bif.bus_resp_i   = rd_pend && !withhold && (rd_wait == resp_d);
  assign bif.bus_rdata_bi = bif.bus_resp_i ? pat(raddr_q) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (bif.bus_req_o && !bif.bus_ack_i) ack_wait <= ack_wait + 1;
    else ack_wait <= 0;
    if (bif.bus_req_o && bif.bus_ack_i && !bif.bus_we_o) begin
      rd_pend <= 1'b1;
      rd_wait <= 1;
      raddr_q <= bif.bus_addr_bo;
    end else if (rd_pend) begin
      if (bif.bus_resp_i) rd_pend <= 1'b0;
      else if (rd_wait < 1000) rd_wait <= rd_wait + 1;
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  logic [31:0] rd_log[$];
  logic [31:0] wmem[logic [31:0]];
  int          wr_cnt = 0;
  int          req_cycles = 0;
  bit          prev_wait = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;

  always @(negedge clk) begin
    if (bif.bus_req_o) req_cycles++;
    if (bif.bus_req_o && bif.bus_ack_i) begin
      if (bif.bus_we_o) begin
        wmem[bif.bus_addr_bo] = bif.bus_wdata_bo;
        wr_cnt++;
      end else begin
        rd_log.push_back(bif.bus_addr_bo);
      end
    end
    if (prev_wait && rst_i) begin
      check("req_held", {31'b0, bif.bus_req_o}, 32'd1);
      check("we_stable", {31'b0, bif.bus_we_o}, {31'b0, prev_we});
      check("addr_stable", bif.bus_addr_bo, prev_addr);
      check("wdata_stable", bif.bus_wdata_bo, prev_wdata);
    end
    prev_wait  = bif.bus_req_o && !bif.bus_ack_i;
    prev_we    = bif.bus_we_o;
    prev_addr  = bif.bus_addr_bo;
    prev_wdata = bif.bus_wdata_bo;
  end

  // ---------------- reference timing model ----------------
  function automatic int model_done(input int len, input int a, input int r);
    // each word: read request (a+1), response wait (r), write request (a+1)
    if (len == 0) return 1;
    return len * (2 * a + 2 + r) + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] sa, da, ea;
    int cyc, done_cyc;
    bit aborted;
    sa = v.src & ~32'h3;
    da = v.dst & ~32'h3;
    rd_log.delete();
    wmem.delete();
    wr_cnt = 0;
    req_cycles = 0;
    ack_d = v.ack_d;
    resp_d = v.resp_d;
    withhold = v.withhold;
    aborted = 1'b0;

    @(negedge clk);
    start_i = 1'b1;
    src_bi = v.src;
    dst_bi = v.dst;
    len_bi = 16'(v.len);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    src_bi = $urandom;
    dst_bi = $urandom;
    len_bi = 16'($urandom);

    cyc = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 2000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check($sformatf("v%0d_busy_c1", idx), {31'b0, busy_o}, 32'd1);
        check($sformatf("v%0d_err_clr", idx), {31'b0, err_o}, 32'd0);
        check($sformatf("v%0d_cnt_clr", idx), {16'b0, cnt_bo}, 32'd0);
      end
      if (abort_i) abort_i = 1'b0;
      else if (v.abort_word > 0 && !aborted && rd_log.size() == v.abort_word) begin
        abort_i = 1'b1;
        aborted = 1'b1;
      end
      if (done_o) done_cyc = cyc;
    end
    abort_i = 1'b0;

    check($sformatf("v%0d_done_seen", idx), {31'b0, (done_cyc >= 0)}, 32'd1);
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d_cnt", idx), {16'b0, cnt_bo}, v.exp_cnt);
    check($sformatf("v%0d_err", idx), {31'b0, err_o}, {31'b0, v.exp_err});

    @(negedge clk);
    #1;
    check($sformatf("v%0d_done_1cyc", idx), {31'b0, done_o}, 32'd0);
    check($sformatf("v%0d_idle", idx), {31'b0, busy_o}, 32'd0);
    check($sformatf("v%0d_cnt_hold", idx), {16'b0, cnt_bo}, v.exp_cnt);
    check($sformatf("v%0d_err_sticky", idx), {31'b0, err_o}, {31'b0, v.exp_err});
    check($sformatf("v%0d_nreads", idx), rd_log.size(), v.exp_reads);
    check($sformatf("v%0d_nwrites", idx), wr_cnt, v.exp_cnt);
    if (v.exp_reads == 0)
      check($sformatf("v%0d_no_req", idx), req_cycles, 32'd0);
    for (int i = 0; i < rd_log.size(); i++)
      check($sformatf("v%0d_raddr%0d", idx, i), rd_log[i], sa + 32'(4 * i));
    for (int i = 0; i < v.exp_cnt; i++) begin
      ea = da + 32'(4 * i);
      check($sformatf("v%0d_wexists%0d", idx, i), {31'b0, wmem.exists(ea)}, 32'd1);
      if (wmem.exists(ea))
        check($sformatf("v%0d_wdata%0d", idx, i), wmem[ea], pat(sa + 32'(4 * i)));
    end
  endtask

  // ---------------- main ----------------
  vec_t vecs[NVEC];

  initial begin
    //            src           dst           len ack rsp abt hold done cnt rds err
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 4, 0, 1, 0, 1'b0, 13, 4, 4, 1'b0};
    vecs[1] = '{32'h0000_0100, 32'h0000_0200, 0, 0, 1, 0, 1'b0,  1, 0, 0, 1'b0};
    vecs[2] = '{32'hFFFF_FFF8, 32'h0000_0300, 3, 0, 1, 0, 1'b0, 10, 3, 3, 1'b0};
    vecs[3] = '{32'h0000_0400, 32'h0000_0500, 3, 2, 3, 0, 1'b0, 28, 3, 3, 1'b0};
    vecs[4] = '{32'h0000_0900, 32'h0000_0A00, 8, 0, 1, 3, 1'b0, 10, 3, 3, 1'b0};
    vecs[5] = '{32'h0000_0600, 32'h0000_0B00, 2, 0, 1, 0, 1'b1,  7, 0, 1, 1'b1};
    vecs[6] = '{32'h0000_0703, 32'h0000_0801, 2, 0, 1, 0, 1'b0,  7, 2, 2, 1'b0};
    for (int i = 7; i < NVEC; i++) begin
      vecs[i].src = 32'h1000_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      vecs[i].dst = 32'h2000_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      vecs[i].len = $urandom_range(1, 6);
      vecs[i].ack_d = $urandom_range(0, 2);
      vecs[i].resp_d = $urandom_range(1, 3);
      vecs[i].abort_word = 0;
      vecs[i].withhold = 1'b0;
      vecs[i].exp_done = model_done(vecs[i].len, vecs[i].ack_d, vecs[i].resp_d);
      vecs[i].exp_cnt = vecs[i].len;
      vecs[i].exp_reads = vecs[i].len;
      vecs[i].exp_err = 1'b0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, bif.bus_req_o}, 32'd0);
    check("rst_we", {31'b0, bif.bus_we_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_cnt", {16'b0, cnt_bo}, 32'd0);
    check("rst_addr", bif.bus_addr_bo, 32'd0);
    check("rst_wdata", bif.bus_wdata_bo, 32'd0);
    check("rst_be", {28'b0, bif.bus_be_bo}, 32'hf);
    check("rst_state", {29'b0, state_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // abort_i while IDLE must not affect the next transfer
    @(negedge clk);
    abort_i = 1'b1;
    repeat (2) @(negedge clk);
    abort_i = 1'b0;
    run_vec(vecs[0], 100);

    // reset in the middle of a transfer
    ack_d = 0;
    resp_d = 1;
    withhold = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    src_bi = 32'h0000_0C00;
    dst_bi = 32'h0000_0D00;
    len_bi = 16'd8;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, bif.bus_req_o}, 32'd0);
    check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    check("mid_rst_done", {31'b0, done_o}, 32'd0);
    check("mid_rst_cnt", {16'b0, cnt_bo}, 32'd0);
    check("mid_rst_addr", bif.bus_addr_bo, 32'd0);
    check("mid_rst_be", {28'b0, bif.bus_be_bo}, 32'hf);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    req_cycles = 0;
    begin
      int done_seen;
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done_o) done_seen++;
      end
      check("post_rst_no_req", req_cycles, 32'd0);
      check("post_rst_no_done", done_seen, 32'd0);
    end

    // a normal transfer still works after the mid-transfer reset
    run_vec(vecs[7], 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
